checked_mux: RTL and testbench

- Parameterized CHANNELS:1 word multiplexer, CHANNELS = 2**SIZE, WIDTH bits per channel, with a combinational data path.
- Adds a registered output stage and a clocked lockstep self-checker. The checker recomputes the selection independently and flags any mismatch, giving sticky and counted error status.
- Sits in datapaths and in unit benches as a self-checking selector.

---
 rtl/checked_mux.sv | 114 +++++++++++
 tb/tb_checked_mux.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/checked_mux.sv
// CHANNELS:1 word multiplexer with a registered copy of the selected word and a
// lockstep checker that recomputes the selection and reports mismatches.
module checked_mux #(
    parameter int WIDTH = 3,
    parameter int SIZE  = 3,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [(2**SIZE)*WIDTH-1:0]  in,
    input  logic [SIZE-1:0]             sel,
    input  logic                        check_en,
    input  logic                        clear,
    output logic [WIDTH-1:0]            out,
    output logic [WIDTH-1:0]            out_q,
    output logic                        err,
    output logic                        err_sticky,
    output logic [CNT_W-1:0]            err_cnt,
    output logic [CNT_W-1:0]            smp_cnt
);

    localparam int CHANNELS = 2**SIZE;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SIZE-1:0]           sel_q;
    logic [CHANNELS*WIDTH-1:0] in_q;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic                      err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]          err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]          smp_cnt_q, smp_cnt_d;
    logic [WIDTH-1:0]          exp_s;
    logic                      mismatch_s;

    // Reference selection: a priority scan over channels, deliberately not the
    // indexed part-select used by the data path, so a common-mode fault is unlikely.
    function automatic logic [WIDTH-1:0] ref_pick(
        input logic [CHANNELS*WIDTH-1:0] v,
        input logic [SIZE-1:0]           s
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s == SIZE'(i)) begin
                r = v[i*WIDTH +: WIDTH];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign out = in[sel*WIDTH +: WIDTH];

    // Compare the registered output against the recomputed selection and
    // derive next status; clear outranks any increment or set.
    always_comb begin
        exp_s        = ref_pick(in_q, sel_q);
        mismatch_s   = valid_q && (out_q != exp_s);
        valid_d      = 1'b0;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        if (clear) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
            smp_cnt_d    = '0;
        end else begin
            valid_d      = check_en;
            err_d        = mismatch_s;
            err_sticky_d = err_sticky_q | mismatch_s;
            if (mismatch_s && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (valid_q && (smp_cnt_q != CNT_MAX)) begin
                smp_cnt_d = smp_cnt_q + CNT_W'(1);
            end else begin
                smp_cnt_d = smp_cnt_q;
            end
        end
    end

    // Output register, capture stage and checker status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q        <= '0;
            sel_q        <= '0;
            in_q         <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            smp_cnt_q    <= '0;
        end else begin
            out_q        <= out;
            sel_q        <= sel;
            in_q         <= in;
            valid_q      <= valid_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
        end
    end

    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign smp_cnt    = smp_cnt_q;

endmodule

// File: tb/tb_checked_mux.sv
// Directed bench for checked_mux: default 3x8 instance, a CNT_W=2 instance for
// saturation and a WIDTH=1/SIZE=1 instance for the bit-mux corner.
module tb_checked_mux;

    logic        clk;
    logic        reset;
    logic [23:0] in;
    logic [2:0]  sel;
    logic        check_en;
    logic        clear;
    logic        clear_s;
    logic [1:0]  in_c;
    logic        sel_c;

    logic [2:0]  out, out_q, out_s, out_q_s;
    logic        err, err_sticky, err_s, err_sticky_s;
    logic [7:0]  err_cnt, smp_cnt;
    logic [1:0]  err_cnt_s, smp_cnt_s;
    logic        out_c, out_q_c, err_c, err_sticky_c;
    logic [7:0]  err_cnt_c, smp_cnt_c;

    int n_chk  = 0;
    int n_fail = 0;

    checked_mux #(.WIDTH(3), .SIZE(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in(in), .sel(sel), .check_en(check_en), .clear(clear),
        .out(out), .out_q(out_q), .err(err), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .smp_cnt(smp_cnt)
    );

    checked_mux #(.WIDTH(3), .SIZE(3), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .in(in), .sel(sel), .check_en(check_en), .clear(clear_s),
        .out(out_s), .out_q(out_q_s), .err(err_s), .err_sticky(err_sticky_s),
        .err_cnt(err_cnt_s), .smp_cnt(smp_cnt_s)
    );

    checked_mux #(.WIDTH(1), .SIZE(1), .CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .in(in_c), .sel(sel_c), .check_en(1'b0), .clear(1'b0),
        .out(out_c), .out_q(out_q_c), .err(err_c), .err_sticky(err_sticky_c),
        .err_cnt(err_cnt_c), .smp_cnt(smp_cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        in       = 24'b111_110_101_100_011_010_001_000;
        sel      = 3'd0;
        check_en = 1'b0;
        clear    = 1'b0;
        clear_s  = 1'b0;
        in_c     = 2'b10;
        sel_c    = 1'b0;
        #12;
        check("rst_out_q", 32'(out_q), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_smp_cnt", 32'(smp_cnt), 32'd0);
        reset = 1'b1;

        // Identity pattern: channel i holds value i
        check_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sel = 3'(k % 8);
            #1;
            check("id_out", 32'(out), 32'(k % 8));
            tick();
            check("id_out_q", 32'(out_q), 32'(k % 8));
            check("id_err", 32'(err), 32'd0);
        end
        check_en = 1'b0;
        tick();
        tick();
        check("id_smp_cnt", 32'(smp_cnt), 32'd10);
        check("id_err_cnt", 32'(err_cnt), 32'd0);
        check("id_sticky", 32'(err_sticky), 32'd0);

        // Reset mid-run
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_smp_cnt", 32'(smp_cnt), 32'd0);
        check_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sel = 3'(k);
            tick();
        end
        check("pre_rst_out_q", 32'(out_q), 32'd5);
        check("pre_rst_smp", 32'(smp_cnt), 32'd4);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out_q", 32'(out_q), 32'd0);
        check("async_rst_smp", 32'(smp_cnt), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        #2;
        reset = 1'b1;
        tick();
        check("post_rst_smp_e1", 32'(smp_cnt), 32'd0);
        tick();
        check("post_rst_smp_e2", 32'(smp_cnt), 32'd1);
        check("post_rst_err", 32'(err), 32'd0);

        // Fault injection: one valid compare against a forced wrong out_q
        check_en = 1'b0;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        check_en = 1'b1;
        sel      = 3'd3;
        tick();
        check_en = 1'b0;
        force dut.out_q = 3'd6;
        tick();
        release dut.out_q;
        check("fi_err", 32'(err), 32'd1);
        check("fi_sticky", 32'(err_sticky), 32'd1);
        check("fi_err_cnt", 32'(err_cnt), 32'd1);
        check("fi_smp_cnt", 32'(smp_cnt), 32'd1);
        tick();
        check("fi_err_pulse", 32'(err), 32'd0);
        check("fi_sticky_hold", 32'(err_sticky), 32'd1);
        check("fi_out_q_back", 32'(out_q), 32'd3);

        // check_en gating with a standing fault
        force dut.out_q = 3'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("gate_err", 32'(err), 32'd0);
        end
        release dut.out_q;
        tick();
        check("gate_smp_cnt", 32'(smp_cnt), 32'd1);
        check("gate_err_cnt", 32'(err_cnt), 32'd1);

        // Clear on the same edge as a mismatch
        check_en = 1'b1;
        sel      = 3'd3;
        tick();
        check_en = 1'b0;
        force dut.out_q = 3'd6;
        clear = 1'b1;
        tick();
        release dut.out_q;
        clear = 1'b0;
        check("clrp_err", 32'(err), 32'd0);
        check("clrp_sticky", 32'(err_sticky), 32'd0);
        check("clrp_err_cnt", 32'(err_cnt), 32'd0);
        check("clrp_smp_cnt", 32'(smp_cnt), 32'd0);
        tick();

        // Saturation on the CNT_W=2 instance
        clear_s = 1'b1;
        tick();
        clear_s = 1'b0;
        check("sat_clr", 32'(smp_cnt_s), 32'd0);
        check_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sel = 3'(k);
            tick();
        end
        check_en = 1'b0;
        tick();
        tick();
        check("sat_smp_cnt", 32'(smp_cnt_s), 32'd3);
        tick();
        tick();
        check("sat_hold", 32'(smp_cnt_s), 32'd3);
        check("sat_err_cnt", 32'(err_cnt_s), 32'd0);
        check("sat_err", 32'(err_s), 32'd0);
        check("sat_sticky", 32'(err_sticky_s), 32'd0);
        check("sat_out", 32'(out_s), 32'd5);
        check("sat_out_q", 32'(out_q_s), 32'd5);

        // WIDTH=1, SIZE=1 corner
        sel_c = 1'b0;
        #1;
        check("bit_out0", 32'(out_c), 32'd0);
        sel_c = 1'b1;
        #1;
        check("bit_out1", 32'(out_c), 32'd1);
        tick();
        check("bit_out_q", 32'(out_q_c), 32'd1);
        check("bit_err", 32'(err_c), 32'd0);
        check("bit_sticky", 32'(err_sticky_c), 32'd0);
        check("bit_err_cnt", 32'(err_cnt_c), 32'd0);
        check("bit_smp_cnt", 32'(smp_cnt_c), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
